// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS32 datapath front end.
//   WORD_W / ADDR_W    : instruction word width and word-address width
//   RESET_PC_DEFAULT   : word address loaded on reset (byte 0x0000_3000)
//   TIMEOUT_DEFAULT    : default WAIT-state timeout in cycles
//   fetch_state_e      : fetch engine states IDLE / REQ / WAIT
//   word_to_byte()     : word address -> byte address
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;
    localparam int                TIMEOUT_DEFAULT  = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] word_to_byte(input logic [ADDR_W-1:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// ---------------------------------------------------------------------------
// fetch_timeout_ctr
// Cycle counter used to bound the time the fetch engine spends in WAIT.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reset the count to zero (takes priority over en)
//   en         : advance the count by one
//   expired    : count has reached TIMEOUT-1 (the last allowed WAIT cycle)
// ---------------------------------------------------------------------------
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // At least one bit so TIMEOUT = 1 still yields a legal counter.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != LAST)) begin
            // Saturates at LAST so a late enable can never wrap the count.
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch engine.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pc_we, npc   : commit strobe and next word address (cur_pc <= npc)
//   fetch_start  : start a fetch at the current PC (accepted only when idle)
//   cur_pc, pc32 : current PC as word address / byte address
//   imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata
//                : request/grant/response instruction-memory port
//   ir, ir_valid : instruction register and its validity for cur_pc
//   busy         : a fetch is in flight (REQ or WAIT)
//   fetch_err    : one-cycle pulse when a fetch is abandoned on timeout
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_we,
    input  logic [ADDR_W-1:0] npc,
    input  logic              fetch_start,
    output logic [ADDR_W-1:0] cur_pc,
    output logic [WORD_W-1:0] pc32,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    localparam logic [1:0] ST_IDLE = FETCH_IDLE;
    localparam logic [1:0] ST_REQ  = FETCH_REQ;
    localparam logic [1:0] ST_WAIT = FETCH_WAIT;

    logic [1:0]        state_reg,    state_next;
    logic [ADDR_W-1:0] cur_pc_reg,   cur_pc_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic              req_reg,      req_next;
    logic [WORD_W-1:0] ir_reg,       ir_next;
    logic              ir_valid_reg, ir_valid_next;
    logic              stale_reg,    stale_next;
    logic              err_reg,      err_next;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_expired;
    logic capture;
    logic in_flight;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_WAIT);

    always_comb begin
        state_next    = state_reg;
        cur_pc_next   = pc_we ? npc : cur_pc_reg;
        addr_next     = addr_reg;
        req_next      = req_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        stale_next    = stale_reg;
        err_next      = 1'b0;
        ctr_clr       = 1'b0;
        ctr_en        = 1'b0;
        capture       = 1'b0;

        // Any commit moves cur_pc away from whatever ir holds.
        if (pc_we) begin
            ir_valid_next = 1'b0;
        end
        // The handshake cannot be withdrawn, so a redirect while in flight
        // only marks the eventual response for discard.
        if (pc_we && in_flight) begin
            stale_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (fetch_start) begin
                    state_next    = ST_REQ;
                    req_next      = 1'b1;
                    // A commit in the same cycle means the fetch targets the new PC.
                    addr_next     = pc_we ? npc : cur_pc_reg;
                    ir_valid_next = 1'b0;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    req_next = 1'b0;
                    if (imem_rvalid) begin
                        capture    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ctr_clr    = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (ctr_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    // Abandoned fetch: nothing left to discard.
                    stale_next = 1'b0;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase

        // A response that coincides with a commit belongs to the old PC and
        // is dropped just like one flagged stale earlier.
        if (capture) begin
            if (stale_reg || pc_we) begin
                stale_next = 1'b0;
            end else begin
                ir_next       = imem_rdata;
                ir_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cur_pc_reg   <= RESET_PC;
            addr_reg     <= RESET_PC;
            req_reg      <= 1'b0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            stale_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_pc_reg   <= cur_pc_next;
            addr_reg     <= addr_next;
            req_reg      <= req_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            stale_reg    <= stale_next;
            err_reg      <= err_next;
        end
    end

    assign cur_pc    = cur_pc_reg;
    assign pc32      = word_to_byte(cur_pc_reg);
    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;
    assign ir        = ir_reg;
    assign ir_valid  = ir_valid_reg;
    assign busy      = in_flight;
    assign fetch_err = err_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit with TIMEOUT = 4. A table of fetch
// transactions (commit-with-fetch, response latency, expected results) is
// replayed in a loop; redirect, idle-commit and mid-fetch reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_we;
    logic [29:0] npc;
    logic        fetch_start;
    logic [29:0] cur_pc;
    logic [31:0] pc32;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_errs   = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC (30'h0000_0C00),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_we       (pc_we),
        .npc         (npc),
        .fetch_start (fetch_start),
        .cur_pc      (cur_pc),
        .pc32        (pc32),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always @(negedge clk) begin
        if (fetch_err) err_pulses <= err_pulses + 1;
    end

    typedef struct {
        logic        pc_we;
        logic [29:0] npc;
        int          lat;       // WAIT cycle carrying rvalid; 0 = with grant
        logic [31:0] rdata;
        logic [29:0] exp_addr;
        logic [31:0] exp_ir;
        logic        exp_valid;
        logic        exp_err;
        int          exp_cyc;   // edges from REQ until back in IDLE
        logic [29:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int err_base;
        bit done;
        @(posedge clk); #1;
        fetch_start = 1'b1;
        pc_we       = v.pc_we;
        npc         = v.npc;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        pc_we       = 1'b0;
        chk($sformatf("v%0d req", idx), 32'(imem_req), 32'd1);
        chk($sformatf("v%0d addr", idx), 32'(imem_addr), 32'(v.exp_addr));
        imem_gnt = 1'b1;
        if (v.lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = v.rdata;
        end
        err_base = err_pulses;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!busy) done = 1'b1;
            else if (cyc == v.lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = v.rdata;
            end
        end
        chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d ir", idx), ir, v.exp_ir);
        chk($sformatf("v%0d ir_valid", idx), 32'(ir_valid), 32'(v.exp_valid));
        chk($sformatf("v%0d fetch_err", idx), 32'(fetch_err), 32'(v.exp_err));
        chk($sformatf("v%0d cur_pc", idx), 32'(cur_pc), 32'(v.exp_pc));
        chk($sformatf("v%0d pc32", idx), pc32, {v.exp_pc, 2'b00});
        @(posedge clk); #1;
        chk($sformatf("v%0d err_cleared", idx), 32'(fetch_err), 32'd0);
        chk($sformatf("v%0d err_pulses", idx), 32'(err_pulses - err_base), 32'(v.exp_err));
        $display("vec %0d: addr=%h lat=%0d ir=%h ir_valid=%0d err=%0d cycles=%0d",
                 idx, v.exp_addr, v.lat, ir, ir_valid, fetch_err, cyc);
    endtask

    initial begin
        // pc_we npc lat rdata addr ir valid err cyc pc
        vecs[0] = '{1'b0, 30'h0, 0, 32'h2008_0005, 30'h0C00, 32'h2008_0005, 1'b1, 1'b0, 1, 30'h0C00};
        vecs[1] = '{1'b1, 30'h0C01, 0, 32'h8C09_0004, 30'h0C01, 32'h8C09_0004, 1'b1, 1'b0, 1, 30'h0C01};
        vecs[2] = '{1'b0, 30'h0, 3, 32'h0123_4567, 30'h0C01, 32'h0123_4567, 1'b1, 1'b0, 4, 30'h0C01};
        vecs[3] = '{1'b1, 30'h3FFF_FFFF, 1, 32'hAAAA_5555, 30'h3FFF_FFFF, 32'hAAAA_5555, 1'b1, 1'b0, 2, 30'h3FFF_FFFF};
        vecs[4] = '{1'b0, 30'h0, 99, 32'hFFFF_FFFF, 30'h3FFF_FFFF, 32'hAAAA_5555, 1'b0, 1'b1, 5, 30'h3FFF_FFFF};
        vecs[5] = '{1'b0, 30'h0, 4, 32'h1111_2222, 30'h3FFF_FFFF, 32'h1111_2222, 1'b1, 1'b0, 5, 30'h3FFF_FFFF};

        rst_n       = 1'b0;
        pc_we       = 1'b0;
        npc         = '0;
        fetch_start = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst cur_pc", 32'(cur_pc), 32'h0000_0C00);
        chk("rst pc32", pc32, 32'h0000_3000);
        chk("rst ir", ir, 32'h0);
        chk("rst ir_valid", 32'(ir_valid), 32'd0);
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", 32'(imem_addr), 32'h0000_0C00);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fetch_err", 32'(fetch_err), 32'd0);
        $display("reset: cur_pc=%h pc32=%h", cur_pc, pc32);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Redirect in WAIT: response dropped, stray fetch_start ignored.
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        pc_we       = 1'b1;
        npc         = 30'h0C10;
        fetch_start = 1'b1;
        @(posedge clk); #1;
        pc_we       = 1'b0;
        fetch_start = 1'b0;
        chk("redir cur_pc", 32'(cur_pc), 32'h0000_0C10);
        chk("redir ir_valid", 32'(ir_valid), 32'd0);
        chk("redir busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        chk("redir idle", 32'(busy), 32'd0);
        chk("redir ir kept", ir, 32'h1111_2222);
        chk("redir ir_valid dropped", 32'(ir_valid), 32'd0);
        @(posedge clk); #1;
        chk("no queued fetch", 32'(busy), 32'd0);
        chk("no queued req", 32'(imem_req), 32'd0);
        $display("redirect: cur_pc=%h ir=%h ir_valid=%0d", cur_pc, ir, ir_valid);

        // Next fetch goes to the redirected PC and is no longer stale.
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        chk("post-redir addr", 32'(imem_addr), 32'h0000_0C10);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2409_0001;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("post-redir ir", ir, 32'h2409_0001);
        chk("post-redir ir_valid", 32'(ir_valid), 32'd1);
        $display("post-redirect fetch: addr=%h ir=%h ir_valid=%0d", imem_addr, ir, ir_valid);

        // Commit in IDLE invalidates ir but keeps its contents.
        pc_we = 1'b1;
        npc   = 30'h0C20;
        @(posedge clk); #1;
        pc_we = 1'b0;
        chk("idle commit cur_pc", 32'(cur_pc), 32'h0000_0C20);
        chk("idle commit ir_valid", 32'(ir_valid), 32'd0);
        chk("idle commit ir", ir, 32'h2409_0001);
        $display("idle commit: cur_pc=%h ir_valid=%0d", cur_pc, ir_valid);

        // Reset in WAIT, then a late response after release.
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("midrst cur_pc", 32'(cur_pc), 32'h0000_0C00);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst req", 32'(imem_req), 32'd0);
        chk("midrst addr", 32'(imem_addr), 32'h0000_0C00);
        chk("midrst ir", ir, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        chk("late rsp ir", ir, 32'h0);
        chk("late rsp ir_valid", 32'(ir_valid), 32'd0);
        chk("late rsp busy", 32'(busy), 32'd0);
        chk("total err pulses", 32'(err_pulses), 32'd1);
        $display("mid-fetch reset: cur_pc=%h ir=%h ir_valid=%0d", cur_pc, ir, ir_valid);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
